// File: rtl/arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks.
//   state_t    : sequencing states of the serial datapath
//   num_digits : number of DIGIT-wide slices in a WIDTH-bit operand
//   idx_width  : width of a slice index register (at least one bit)
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_slice.sv
// Pure combinational ripple-carry adder slice.
//   a, b  : DIGIT-bit addends
//   cin   : carry in
//   sum   : DIGIT-bit sum
//   cout  : carry out of the top bit
module add_slice #(
    parameter int unsigned DIGIT = 3
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    always_comb begin : ripple
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: out_diff = in_a - in_b - in_bin (mod 2^WIDTH),
// resolved DIGIT bits per clock with the borrow carried in a register.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (ready only while idle)
//   in_a, in_b, in_bin  : minuend, subtrahend, borrow in
//   out_valid, out_ready: result handshake (valid only while done)
//   out_diff            : difference
//   out_bout            : unsigned borrow out (a < b + bin)
//   out_ovf             : two's-complement overflow
//   busy                : a transaction is in flight
module digit_serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned    N        = num_digits(WIDTH, DIGIT);
    localparam int unsigned    IDXW     = idx_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    generate
        if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
            $error("digit_serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic [WIDTH-1:0]  diff_next;
    logic [IDXW-1:0]   idx_q;
    logic              borrow_q;
    logic              bout_q;
    logic              ovf_q;
    logic              a_msb_q;
    logic              b_msb_q;

    logic              accept;
    logic              last_slice;
    logic [DIGIT-1:0]  slice_a;
    logic [DIGIT-1:0]  slice_b_n;
    logic              slice_cin;
    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout;

    // Operands are shifted right each cycle so the active slice always sits
    // in the low DIGIT bits; the result is shifted in from the top so it is
    // aligned after the last slice. Equivalent to indexing slice idx directly.
    always_comb begin
        slice_a   = a_q[DIGIT-1:0];
        slice_b_n = ~b_q[DIGIT-1:0];
        slice_cin = ~borrow_q;
    end

    add_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b_n),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    generate
        if (N > 1) begin : g_multi
            always_comb diff_next = {slice_sum, diff_q[WIDTH-1:DIGIT]};
        end else begin : g_single
            always_comb diff_next = slice_sum;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        last_slice = (idx_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                in_ready = rst_n;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= in_bin;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= in_a[WIDTH-1];
            b_msb_q  <= in_b[WIDTH-1];
        end else if (state_q == RUN) begin
            a_q      <= a_q >> DIGIT;
            b_q      <= b_q >> DIGIT;
            diff_q   <= diff_next;
            borrow_q <= ~slice_cout;
            if (last_slice) begin
                bout_q <= ~slice_cout;
                ovf_q  <= (a_msb_q != b_msb_q) && (slice_sum[DIGIT-1] != a_msb_q);
            end else begin
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_diff = diff_q;
        out_bout = bout_q;
        out_ovf  = ovf_q;
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
module tb_digit_serial_subtractor;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned DIGIT = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
    logic             out_ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    digit_serial_subtractor #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_bout  (out_bout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge; returns after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Operand ports are free to change while the block runs.
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_bin   = 1'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_result(input string tag, input logic [WIDTH-1:0] ed,
                               input logic eb, input logic eo);
        int edges;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd4);
        check({tag, "_diff"},    {20'd0, out_diff}, {20'd0, ed});
        check({tag, "_bout"},    {31'd0, out_bout}, {31'd0, eb});
        check({tag, "_ovf"},     {31'd0, out_ovf},  {31'd0, eo});
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic release_result(input int delay);
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_after_release", {31'd0, out_valid}, 32'd0);
        check("busy_after_release",  {31'd0, busy},      32'd0);
    endtask

    initial begin
        logic [WIDTH:0]   ref_full;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rbin;
        logic             ref_ovf;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_diff",      {20'd0, out_diff},  32'd0);
        check("rst_bout",      {31'd0, out_bout},  32'd0);
        check("rst_ovf",       {31'd0, out_ovf},   32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors.
        issue(12'h7D3, 12'h2A1, 1'b0);
        wait_result("basic", 12'h532, 1'b0, 1'b0);
        release_result(0);

        issue(12'h000, 12'h001, 1'b0);
        wait_result("ripple", 12'hFFF, 1'b1, 1'b0);
        release_result(1);

        issue(12'h800, 12'h001, 1'b0);
        wait_result("ovf", 12'h7FF, 1'b0, 1'b1);
        release_result(0);

        issue(12'h005, 12'h005, 1'b1);
        wait_result("bin", 12'hFFF, 1'b1, 1'b0);
        release_result(0);

        // Back-pressure: result held, new requests ignored.
        issue(12'h7D3, 12'h2A1, 1'b0);
        wait_result("bp", 12'h532, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a     = 12'h111;
        in_b     = 12'h222;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_diff",     {20'd0, out_diff},  32'h532);
            check("bp_in_ready", {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        release_result(0);

        // Reset during slice 2 of a run.
        issue(12'hABC, 12'h123, 1'b0);
        repeat (2) @(negedge clk);
        check("midrun_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy",      {31'd0, busy},      32'd0);
        check("midrst_diff",      {20'd0, out_diff},  32'd0);
        check("midrst_bout",      {31'd0, out_bout},  32'd0);
        check("midrst_ovf",       {31'd0, out_ovf},   32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(12'h123, 12'h045, 1'b0);
        wait_result("after_rst", 12'h0DE, 1'b0, 1'b0);
        release_result(0);

        // Random vectors against an arithmetic reference.
        for (int n = 0; n < 300; n++) begin
            ra       = WIDTH'($urandom);
            rb       = WIDTH'($urandom);
            rbin     = 1'($urandom);
            ref_full = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
            ref_ovf  = (ra[WIDTH-1] != rb[WIDTH-1]) && (ref_full[WIDTH-1] != ra[WIDTH-1]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ra, rb, rbin);
            wait_result("rand", ref_full[WIDTH-1:0], ref_full[WIDTH], ref_ovf);
            release_result(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
